// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Zero-latency source lookup with commit bypass, flush clears renames.
module reg_rename_file #(
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             rn_en,
  input  logic [4:0]       rn_idx,
  input  logic [TAG_W-1:0] rn_tag,
  input  logic             cm_en,
  input  logic [4:0]       cm_idx,
  input  logic [TAG_W-1:0] cm_tag,
  input  logic [XLEN-1:0]  cm_val,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_ready,
  output logic [XLEN-1:0]  rs1_val,
  output logic             rs2_ready,
  output logic [XLEN-1:0]  rs2_val,
  output logic [5:0]       busy_cnt
);

  logic [XLEN-1:0]  val_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [NREG-1:0]  busy_q;
  logic [5:0]       cnt_q;

  logic       cm_hit;
  logic       rn_hit;
  logic       cm_clr;
  logic       inc;
  logic       dec;
  logic [5:0] cnt_nxt;

  function automatic logic [XLEN:0] lookup(input logic [4:0] a);
    logic [XLEN:0] r;
    r = {1'b1, XLEN'(0)};
    if (a == 5'd0) begin
      r = {1'b1, XLEN'(0)};
    end else if (!busy_q[a]) begin
      r = {1'b1, val_q[a]};
    end else if (cm_en && cm_idx == a && cm_tag == tag_q[a]) begin
      r = {1'b1, cm_val};
    end else begin
      r = {1'b0, XLEN'(tag_q[a])};
    end
    return r;
  endfunction

  // Source lookups: file value, commit bypass, or pending tag
  always_comb begin
    {rs1_ready, rs1_val} = lookup(rs1_addr);
    {rs2_ready, rs2_val} = lookup(rs2_addr);
  end

  // Decode this cycle's commit/rename effects and the busy count delta
  always_comb begin
    cm_hit  = cm_en && cm_idx != 5'd0;
    rn_hit  = rn_en && rn_idx != 5'd0 && !flush;
    cm_clr  = cm_hit && tag_q[cm_idx] == cm_tag
              && !(rn_en && rn_idx == cm_idx);
    inc     = rn_hit && !busy_q[rn_idx];
    dec     = cm_clr && busy_q[cm_idx];
    cnt_nxt = cnt_q + 6'(inc) - 6'(dec);
    if (flush) cnt_nxt = '0;
  end

  // State update; a rename beats a same-cycle commit clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (rdy) begin
      if (cm_hit) val_q[cm_idx] <= cm_val;
      if (flush) begin
        busy_q <= '0;
      end else begin
        if (cm_clr) busy_q[cm_idx] <= 1'b0;
        if (rn_hit) begin
          busy_q[rn_idx] <= 1'b1;
          tag_q[rn_idx]  <= rn_tag;
        end
      end
      cnt_q <= cnt_nxt;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed scenarios plus random traffic
// against an array-based reference model.
module tb_reg_rename_file;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             flush;
  logic             rn_en;
  logic [4:0]       rn_idx;
  logic [TAG_W-1:0] rn_tag;
  logic             cm_en;
  logic [4:0]       cm_idx;
  logic [TAG_W-1:0] cm_tag;
  logic [XLEN-1:0]  cm_val;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_ready;
  logic [XLEN-1:0]  rs1_val;
  logic             rs2_ready;
  logic [XLEN-1:0]  rs2_val;
  logic [5:0]       busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0] m_val  [32];
  bit [3:0]  m_tag  [32];
  bit        m_busy [32];

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rn_en(rn_en), .rn_idx(rn_idx), .rn_tag(rn_tag),
    .cm_en(cm_en), .cm_idx(cm_idx), .cm_tag(cm_tag),
    .cm_val(cm_val),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_ready(rs1_ready), .rs1_val(rs1_val),
    .rs2_ready(rs2_ready), .rs2_val(rs2_val),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit [32:0] m_look(input bit [4:0] a);
    if (a == 0) return {1'b1, 32'h0};
    if (!m_busy[a]) return {1'b1, m_val[a]};
    if (cm_en && cm_idx == a && cm_tag == m_tag[a])
      return {1'b1, cm_val};
    return {1'b0, 28'h0, m_tag[a]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
    end
  endtask

  task automatic m_clock();
    if (!rdy) return;
    if (cm_en && cm_idx != 0) begin
      m_val[cm_idx] = cm_val;
      if (m_tag[cm_idx] == cm_tag && !(rn_en && rn_idx == cm_idx))
        m_busy[cm_idx] = 0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (rn_en && rn_idx != 0) begin
      m_busy[rn_idx] = 1;
      m_tag[rn_idx]  = rn_tag;
    end
  endtask

  task automatic idle();
    rdy = 1; flush = 0; rn_en = 0; rn_idx = 0; rn_tag = 0;
    cm_en = 0; cm_idx = 0; cm_tag = 0; cm_val = 0;
  endtask

  task automatic check_outputs();
    bit [32:0] e1, e2;
    e1 = m_look(rs1_addr);
    e2 = m_look(rs2_addr);
    chk("rs1", {rs1_ready, rs1_val}, 64'(e1));
    chk("rs2", {rs2_ready, rs2_val}, 64'(e2));
    chk("busy_cnt", 64'(busy_cnt), 64'(m_cnt()));
  endtask

  // inputs are set at a negedge; compare, clock, update model
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic rename(input bit [4:0] r, input bit [3:0] t);
    idle(); rn_en = 1; rn_idx = r; rn_tag = t; cycle();
  endtask

  task automatic commit(input bit [4:0] r, input bit [3:0] t,
                        input bit [31:0] v);
    idle(); cm_en = 1; cm_idx = r; cm_tag = t; cm_val = v; cycle();
  endtask

  initial begin
    idle();
    rs1_addr = 0; rs2_addr = 0;
    rst = 0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_cnt", 64'(busy_cnt), 64'd0);
    chk("reset_rs1", {rs1_ready, rs1_val}, {1'b1, 32'h0});
    rst = 1;
    @(negedge clk);

    rename(5, 3);
    rs1_addr = 5; idle(); #1;
    chk("ren_x5", {rs1_ready, rs1_val}, {1'b0, 32'h3});
    chk("ren_cnt", 64'(busy_cnt), 64'd1);
    cycle();

    rs2_addr = 5;
    idle(); cm_en = 1; cm_idx = 5; cm_tag = 3; cm_val = 32'hDEADBEEF;
    #1;
    chk("bypass", {rs2_ready, rs2_val}, {1'b1, 32'hDEADBEEF});
    cycle();
    idle(); #1;
    chk("file_x5", {rs2_ready, rs2_val}, {1'b1, 32'hDEADBEEF});
    chk("cnt_zero", 64'(busy_cnt), 64'd0);
    cycle();

    rename(7, 2);
    rename(7, 9);
    commit(7, 2, 32'h11);
    rs1_addr = 7; idle(); #1;
    chk("stale_x7", {rs1_ready, rs1_val}, {1'b0, 32'h9});
    chk("stale_cnt", 64'(busy_cnt), 64'd1);
    cycle();
    commit(7, 9, 32'h22);

    rename(8, 4);
    idle(); rn_en = 1; rn_idx = 8; rn_tag = 5;
    cm_en = 1; cm_idx = 8; cm_tag = 4; cm_val = 32'h44;
    cycle();
    rs1_addr = 8; idle(); #1;
    chk("clr_ren_x8", {rs1_ready, rs1_val}, {1'b0, 32'h5});
    chk("clr_ren_cnt", 64'(busy_cnt), 64'd1);
    cycle();

    rename(0, 1);
    commit(0, 0, 32'h55);
    rs1_addr = 0; idle(); #1;
    chk("x0", {rs1_ready, rs1_val}, {1'b1, 32'h0});
    cycle();

    rename(10, 1); rename(11, 2);
    idle(); rdy = 0; rn_en = 1; rn_idx = 12; rn_tag = 3; cycle();
    idle(); #1;
    chk("hold_cnt", 64'(busy_cnt), 64'd3);
    flush = 1; rn_en = 1; rn_idx = 13; rn_tag = 6; cycle();
    idle(); #1;
    chk("flush_cnt", 64'(busy_cnt), 64'd0);

    for (int n = 0; n < 600; n++) begin
      idle();
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 24) == 0);
      rn_en = $urandom_range(0, 1);
      rn_idx = 5'($urandom_range(0, 7));
      rn_tag = 4'($urandom);
      cm_en = $urandom_range(0, 1);
      cm_idx = ($urandom_range(0, 1) != 0) ? rn_idx
                                          : 5'($urandom_range(0, 7));
      cm_tag = ($urandom_range(0, 3) != 0) ? m_tag[cm_idx]
                                          : 4'($urandom);
      cm_val = $urandom;
      rs1_addr = ($urandom_range(0, 1) != 0) ? cm_idx : 5'($urandom);
      rs2_addr = 5'($urandom_range(0, 8));
      cycle();
    end

    for (int r = 1; r < 32; r++) rename(5'(r), 4'(r));
    chk("full_cnt", 64'(busy_cnt), 64'd31);
    rename(9, 15);
    chk("full_rerename", 64'(busy_cnt), 64'd31);

    rs1_addr = 5; rs2_addr = 9; idle();
    #3 rst = 0; #1;
    m_reset();
    chk("arst_cnt", 64'(busy_cnt), 64'd0);
    chk("arst_rs1", {rs1_ready, rs1_val}, {1'b1, 32'h0});
    chk("arst_rs2", {rs2_ready, rs2_val}, {1'b1, 32'h0});
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rename(5, 6);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
